// File: rtl/lt24_pixel_scheduler.sv
// lt24_pixel_scheduler
// Shares the LT24 driver's single pixel-write port between a raster-ordered
// camera/classifier stream and an explicitly addressed overlay writer.
// The block keeps the stream's raster position, arbitrates round-robin, and
// holds each pixel in a one-entry output register until the driver takes it.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   cam_valid/ready     stream handshake, cam_pixel data, cam_restart -> (0,0)
//   ovl_valid/ready     overlay handshake, ovl_x/ovl_y address, ovl_pixel data
//   lcd_write/ready     output slot handshake, lcd_xaddr/lcd_yaddr/lcd_pixel
//   frame_done          one-cycle pulse after the last pixel of a frame
//   ovl_err             sticky: an out-of-range overlay pixel was dropped
module lt24_pixel_scheduler #(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int PIXEL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cam_valid,
  input  logic [PIXEL_W-1:0] cam_pixel,
  output logic               cam_ready,
  input  logic               cam_restart,
  input  logic               ovl_valid,
  input  logic [7:0]         ovl_x,
  input  logic [8:0]         ovl_y,
  input  logic [PIXEL_W-1:0] ovl_pixel,
  output logic               ovl_ready,
  output logic               lcd_write,
  output logic [7:0]         lcd_xaddr,
  output logic [8:0]         lcd_yaddr,
  output logic [PIXEL_W-1:0] lcd_pixel,
  input  logic               lcd_ready,
  output logic               frame_done,
  output logic               ovl_err
);

  typedef enum logic {SRC_CAM = 1'b0, SRC_OVL = 1'b1} src_t;

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);
  // One extra bit so WIDTH=256 / HEIGHT=512 still compare correctly.
  localparam logic [8:0] X_LIM  = 9'(WIDTH);
  localparam logic [9:0] Y_LIM  = 10'(HEIGHT);

  src_t       last_src;
  logic [7:0] rx;
  logic [8:0] ry;

  logic slot_free, grant_cam, grant_ovl;
  logic cam_acc, ovl_acc, ovl_ok, raster_end;

  assign slot_free  = !lcd_write || lcd_ready;
  assign cam_acc    = cam_valid && grant_cam;
  assign ovl_acc    = ovl_valid && grant_ovl;
  assign ovl_ok     = ({1'b0, ovl_x} < X_LIM) && ({1'b0, ovl_y} < Y_LIM);
  assign raster_end = (rx == X_LAST) && (ry == Y_LAST);
  assign cam_ready  = grant_cam;
  assign ovl_ready  = grant_ovl;

  // Round-robin: on a tie the source that did not win last time is granted.
  always_comb begin
    grant_cam = 1'b0;
    grant_ovl = 1'b0;
    if (slot_free) begin
      if (cam_valid && ovl_valid) begin
        grant_cam = (last_src == SRC_OVL);
        grant_ovl = (last_src == SRC_CAM);
      end else begin
        grant_cam = cam_valid;
        grant_ovl = ovl_valid;
      end
    end
  end

  // Output stage and arbitration history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lcd_write <= 1'b0;
      lcd_xaddr <= '0;
      lcd_yaddr <= '0;
      lcd_pixel <= '0;
      ovl_err   <= 1'b0;
      last_src  <= SRC_OVL;
    end else if (cam_acc) begin
      lcd_write <= 1'b1;
      lcd_xaddr <= rx;
      lcd_yaddr <= ry;
      lcd_pixel <= cam_pixel;
      last_src  <= SRC_CAM;
    end else if (ovl_acc) begin
      last_src <= SRC_OVL;
      if (ovl_ok) begin
        lcd_write <= 1'b1;
        lcd_xaddr <= ovl_x;
        lcd_yaddr <= ovl_y;
        lcd_pixel <= ovl_pixel;
      end else begin
        // Dropped pixel: the slot was free (or draining) to grant it, so it
        // ends up empty.
        lcd_write <= 1'b0;
        ovl_err   <= 1'b1;
      end
    end else if (lcd_ready) begin
      lcd_write <= 1'b0;
    end
  end

  // Raster position of the next stream pixel. Restart wins over advance,
  // and suppresses the end-of-frame pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx         <= '0;
      ry         <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= cam_acc && raster_end && !cam_restart;
      if (cam_restart) begin
        rx <= '0;
        ry <= '0;
      end else if (cam_acc) begin
        if (rx != X_LAST) begin
          rx <= rx + 8'd1;
        end else begin
          rx <= '0;
          ry <= (ry == Y_LAST) ? 9'd0 : ry + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lt24_pixel_scheduler.sv
// Testbench for lt24_pixel_scheduler: directed phases plus a randomized
// phase, checked every cycle against a transaction-level scoreboard model
// (raster index arithmetic, queue of expected writes), with a few literal
// expectations pinning the model.
module tb_lt24_pixel_scheduler;
  localparam int W = 240;
  localparam int H = 320;

  logic        clock = 1'b0;
  logic        reset;
  logic        cam_valid, cam_restart, ovl_valid, lcd_ready;
  logic [15:0] cam_pixel, ovl_pixel;
  logic [7:0]  ovl_x;
  logic [8:0]  ovl_y;
  logic        cam_ready, ovl_ready, lcd_write, frame_done, ovl_err;
  logic [7:0]  lcd_xaddr;
  logic [8:0]  lcd_yaddr;
  logic [15:0] lcd_pixel;

  lt24_pixel_scheduler #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(16)) dut (
    .clock(clock), .reset(reset),
    .cam_valid(cam_valid), .cam_pixel(cam_pixel), .cam_ready(cam_ready),
    .cam_restart(cam_restart),
    .ovl_valid(ovl_valid), .ovl_x(ovl_x), .ovl_y(ovl_y),
    .ovl_pixel(ovl_pixel), .ovl_ready(ovl_ready),
    .lcd_write(lcd_write), .lcd_xaddr(lcd_xaddr), .lcd_yaddr(lcd_yaddr),
    .lcd_pixel(lcd_pixel), .lcd_ready(lcd_ready),
    .frame_done(frame_done), .ovl_err(ovl_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int x; int y; int p; } ent_t;
  ent_t q[$];          // pixels accepted but not yet taken by the driver
  int   pix_idx = 0;   // raster index of the next stream pixel
  bit   last_cam = 0;  // previous accept came from the stream
  bit   exp_fd = 0;
  bit   exp_err = 0;

  always @(negedge clock) begin
    if (!reset) begin
      q.delete();
      pix_idx  = 0;
      last_cam = 0;
      exp_fd   = 0;
      exp_err  = 0;
    end else begin
      bit sf, cr, orr;
      chk("lcd_write", int'(lcd_write), int'(q.size() != 0));
      if (q.size() != 0) begin
        chk("lcd_xaddr", int'(lcd_xaddr), q[0].x);
        chk("lcd_yaddr", int'(lcd_yaddr), q[0].y);
        chk("lcd_pixel", int'(lcd_pixel), q[0].p);
      end
      chk("frame_done", int'(frame_done), int'(exp_fd));
      chk("ovl_err", int'(ovl_err), int'(exp_err));
      sf  = (q.size() == 0) || lcd_ready;
      cr  = sf && cam_valid && (!ovl_valid || !last_cam);
      orr = sf && ovl_valid && (!cam_valid || last_cam);
      chk("cam_ready", int'(cam_ready), int'(cr));
      chk("ovl_ready", int'(ovl_ready), int'(orr));
      // state after the coming rising edge
      if (q.size() != 0 && lcd_ready) void'(q.pop_front());
      exp_fd = 0;
      if (cr) begin
        q.push_back('{pix_idx % W, pix_idx / W, int'(cam_pixel)});
        last_cam = 1;
        if (cam_restart) pix_idx = 0;
        else begin
          pix_idx++;
          if (pix_idx == W * H) begin pix_idx = 0; exp_fd = 1; end
        end
      end else begin
        if (cam_restart) pix_idx = 0;
        if (orr) begin
          last_cam = 0;
          if (int'(ovl_x) < W && int'(ovl_y) < H)
            q.push_back('{int'(ovl_x), int'(ovl_y), int'(ovl_pixel)});
          else
            exp_err = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_ovl(input bit allow_bad);
    ovl_pixel = 16'($urandom);
    if (allow_bad && $urandom_range(0, 15) == 0) begin
      ovl_x = 8'($urandom_range(0, 255));
      ovl_y = 9'($urandom_range(H, 511));
    end else begin
      ovl_x = 8'($urandom_range(0, W - 1));
      ovl_y = 9'($urandom_range(0, H - 1));
    end
  endtask

  int fd_count;
  bit fd_last;

  initial begin
    reset = 1'b0;
    cam_valid = 0; cam_restart = 0; ovl_valid = 0; lcd_ready = 0;
    cam_pixel = 0; ovl_pixel = 0; ovl_x = 0; ovl_y = 0;
    repeat (3) step();
    chk("rst_lcd_write", int'(lcd_write), 0);
    chk("rst_lcd_xaddr", int'(lcd_xaddr), 0);
    chk("rst_lcd_yaddr", int'(lcd_yaddr), 0);
    chk("rst_lcd_pixel", int'(lcd_pixel), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_ovl_err", int'(ovl_err), 0);
    reset = 1'b1;
    step();

    // Tie after reset: stream first, then alternate.
    lcd_ready = 1; cam_valid = 1; ovl_valid = 1;
    ovl_x = 8'd10; ovl_y = 9'd20; ovl_pixel = 16'hBEEF;
    cam_pixel = 16'($urandom);
    #1;
    chk("tie_first_cam", int'(cam_ready), 1);
    chk("tie_first_ovl", int'(ovl_ready), 0);
    step();
    chk("tie_second_ovl", int'(ovl_ready), 1);
    step();
    chk("ovl_at_10_20_x", int'(lcd_xaddr), 10);
    chk("ovl_at_10_20_p", int'(lcd_pixel), 16'hBEEF);
    for (int i = 0; i < 20; i++) begin
      cam_pixel = 16'($urandom);
      step();
    end

    // Stall with a pixel held, then release with no bubble.
    ovl_valid = 0;
    step();
    lcd_ready = 0;
    repeat (5) step();
    chk("stall_write", int'(lcd_write), 1);
    chk("stall_cam_ready", int'(cam_ready), 0);
    lcd_ready = 1;
    #1;
    chk("release_cam_ready", int'(cam_ready), 1);
    step();

    // Out-of-range overlay is consumed and flagged.
    cam_valid = 0;
    step();
    ovl_valid = 1; ovl_x = 8'd240; ovl_y = 9'd5; ovl_pixel = 16'h1234;
    #1;
    chk("bad_ovl_ready", int'(ovl_ready), 1);
    step();
    ovl_valid = 0;
    repeat (100) step();
    chk("ovl_err_sticky", int'(ovl_err), 1);
    ovl_valid = 1; ovl_x = 8'd239; ovl_y = 9'd319; ovl_pixel = 16'hA5A5;
    step();
    ovl_valid = 0;
    chk("corner_write", int'(lcd_write), 1);
    chk("corner_x", int'(lcd_xaddr), 239);
    chk("corner_y", int'(lcd_yaddr), 319);

    // Randomized mix.
    for (int i = 0; i < 1500; i++) begin
      cam_valid   = ($urandom_range(0, 3) != 0);
      cam_pixel   = 16'($urandom);
      cam_restart = ($urandom_range(0, 63) == 0);
      ovl_valid   = ($urandom_range(0, 2) == 0);
      rand_ovl(1'b1);
      lcd_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    cam_restart = 0; ovl_valid = 0; lcd_ready = 1;

    // Restart coinciding with the accept at (100,3).
    cam_valid = 0; cam_restart = 1;
    step();
    cam_restart = 0; cam_valid = 1;
    for (int i = 0; i < 3 * W + 100; i++) begin
      cam_pixel = 16'($urandom);
      step();
    end
    cam_restart = 1; cam_pixel = 16'h0F0F;
    step();
    cam_restart = 0;
    chk("restart_px_x", int'(lcd_xaddr), 100);
    chk("restart_px_y", int'(lcd_yaddr), 3);
    step();
    chk("after_restart_x", int'(lcd_xaddr), 0);
    chk("after_restart_y", int'(lcd_yaddr), 0);

    // Full frame of stream pixels.
    cam_valid = 0; cam_restart = 1;
    step();
    cam_restart = 0; cam_valid = 1;
    fd_count = 0; fd_last = 0;
    for (int i = 0; i < W * H; i++) begin
      cam_pixel = 16'($urandom);
      step();
      if (frame_done) fd_count++;
      fd_last = frame_done;
    end
    chk("frame_done_count", fd_count, 1);
    chk("frame_done_timing", int'(fd_last), 1);
    step();
    chk("wrap_x", int'(lcd_xaddr), 0);
    chk("wrap_y", int'(lcd_yaddr), 0);
    chk("wrap_fd_low", int'(frame_done), 0);

    // Reset mid-transfer while the driver is stalled.
    repeat (50) step();
    lcd_ready = 0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("async_reset_write", int'(lcd_write), 0);
    step();
    step();
    reset = 1'b1;
    lcd_ready = 1; cam_valid = 1; ovl_valid = 1; rand_ovl(1'b0);
    cam_pixel = 16'h5555;
    #1;
    chk("post_rst_tie_cam", int'(cam_ready), 1);
    step();
    chk("post_rst_x", int'(lcd_xaddr), 0);
    chk("post_rst_y", int'(lcd_yaddr), 0);
    chk("post_rst_p", int'(lcd_pixel), 16'h5555);
    for (int i = 0; i < 200; i++) begin
      cam_valid = $urandom_range(0, 1) == 1;
      ovl_valid = $urandom_range(0, 1) == 1;
      cam_pixel = 16'($urandom);
      rand_ovl(1'b1);
      lcd_ready = $urandom_range(0, 2) != 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
